tmr_recovery_ctrl: RTL and testbench
====================================

// Module: tmr_recovery_ctrl
// PURPOSE
// - Fault-recovery sequencer for the triple-lockstep core cluster; sits beside tmr_voter.
// - Filters voter mismatch flags and identifies the faulty hart.
// - Halts all harts via debug request, waits for the software resync routine, then releases.
// - Escalates to a sticky fatal state on unrecoverable faults.
// PARAMETERS
// - NHARTS        3     harts under vote; only 3 is supported (elaboration $error otherwise)
// - ERR_PERSIST   2     consecutive error cycles required to confirm a fault (>=1)
// - HALT_TIMEOUT  1024  cycles allowed for all harts to report halted (>=2)
// - CNT_W         16    width of the confirmed-fault counter
// PORTS
// - clk_i           in   1       clock
// - rst_ni          in   1       async active-low reset
// - enable_i        in   1       recovery enable; when 0, errors are ignored in IDLE
// - error_i         in   1       voter mismatch flag (combinational from voter)
// - error_id_i      in   NHARTS  one-hot id of the disagreeing hart
// - halted_i        in   NHARTS  per-hart "in debug mode" status
// - resync_done_i   in   1       single-cycle pulse from debug routine: state copy finished
// - debug_req_o     out  NHARTS  debug halt request to each hart
// - faulty_id_o     out  NHARTS  captured one-hot faulty hart; valid while recovering_o
// - recovering_o    out  1       high in HALT_REQ, RESYNC, RELEASE
// - fatal_o         out  1       sticky unrecoverable-fault flag
// - fault_count_o   out  CNT_W   confirmed faults, saturating at all-ones
// BEHAVIOUR
// - Reset: FSM=IDLE; all outputs 0; internal counters 0; captured id 0.
// - Registered FSM; all outputs are decoded from registered state (no comb path from inputs).
// - IDLE: enable_i & error_i & onehot(error_id_i) -> capture id.
//     - ERR_PERSIST==1: go to HALT_REQ.
//     - Otherwise: go to FILTER with persist_cnt=1.
// - IDLE: enable_i & error_i & error_id_i not one-hot (zero or >1 bits) -> FATAL.
// - FILTER: error_i & error_id_i==captured -> persist_cnt++.
//     - When persist_cnt reaches ERR_PERSIST: go to HALT_REQ, fault_count_o++.
// - FILTER: error_i low -> IDLE (transient, not counted).
// - FILTER: different one-hot id -> re-capture, persist_cnt=1.
// - FILTER: non-one-hot id -> FATAL.
// - ERR_PERSIST==1: fault_count_o increments on the IDLE->HALT_REQ transition.
// - HALT_REQ: debug_req_o='1; timeout counter increments each cycle.
//     - &halted_i -> RESYNC.
//     - Counter reaches HALT_TIMEOUT-1 without all halted -> FATAL.
//     - If both occur in the same cycle, halted wins.
// - RESYNC: debug_req_o=0; wait resync_done_i -> RELEASE.
//     - No timeout; software owns this phase.
//     - error_i is ignored from HALT_REQ through RELEASE.
// - RELEASE: wait ~|halted_i (harts executed dret) -> IDLE.
//     - Clear captured id on exit.
// - FATAL: debug_req_o='1, fatal_o=1, recovering_o=0; exits only via reset.
// - enable_i deassert mid-recovery: sequence still completes; enable_i gates only IDLE entry.
// - fault_count_o saturates; no wrap.
// - Async reset mid-sequence drops debug_req_o immediately.
// STRUCTURE
// - cei_mochila_pkg: tmr_rec_state_e enum; TMR_NHARTS constant.
// - Single module; timeout and persist counters inline.
// - Instantiated at cluster top next to tmr_voter; error ports wired from the voter outputs.
// TESTING
// - No fault:
//     - error_i held 0 for 1000 cycles -> state IDLE, all outputs 0.
// - Transient:
//     - error_i=1, id=3'b010 for 1 cycle (ERR_PERSIST=2) -> back to IDLE.
//     - fault_count_o=0, debug_req_o never set.
// - Full recovery:
//     - id=3'b100 for 2 cycles -> debug_req_o=3'b111 the next cycle, faulty_id_o=3'b100.
//     - halted_i=3'b111 -> debug_req_o=0.
//     - resync_done_i pulse, then halted_i=0 -> IDLE, fault_count_o=1.
// - Halt timeout:
//     - Confirmed fault, halted_i=3'b011 forever.
//     - After 1024 cycles in HALT_REQ -> fatal_o=1 (sticky until rst_ni).
// - Ambiguous id:
//     - error_i=1, id=3'b011 -> FATAL on the next clock edge.
// - Reset mid-RESYNC:
//     - Assert rst_ni=0 -> all outputs 0 asynchronously; fault_count_o=0.
//     - enable_i=0 plus error pulse -> no action.

Source files
------------

// File: rtl/cei_mochila_pkg.sv
// Shared types for the lockstep-cluster recovery sequencer.
// Holds the recovery FSM encoding and the supported hart count.
package cei_mochila_pkg;

  localparam int TMR_NHARTS = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILTER   = 3'd1,
    ST_HALT_REQ = 3'd2,
    ST_RESYNC   = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_FATAL    = 3'd5
  } tmr_rec_state_e;

endpackage

// File: rtl/tmr_recovery_ctrl.sv
// Fault-recovery sequencer: filters voter mismatches, halts harts, waits for resync, releases.
// Outputs are decoded from registered state only, so they react one clock after the inputs.
module tmr_recovery_ctrl
  import cei_mochila_pkg::*;
#(
  parameter int NHARTS       = 3,
  parameter int ERR_PERSIST  = 2,
  parameter int HALT_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              error_i,
  input  logic [NHARTS-1:0] error_id_i,
  input  logic [NHARTS-1:0] halted_i,
  input  logic              resync_done_i,
  output logic [NHARTS-1:0] debug_req_o,
  output logic [NHARTS-1:0] faulty_id_o,
  output logic              recovering_o,
  output logic              fatal_o,
  output logic [CNT_W-1:0]  fault_count_o
);

  localparam int PW = (ERR_PERSIST < 2) ? 1 : $clog2(ERR_PERSIST + 1);
  localparam int TW = $clog2(HALT_TIMEOUT);

  if (NHARTS != TMR_NHARTS) begin : g_bad_nharts
    $error("tmr_recovery_ctrl supports only NHARTS == 3");
  end

  tmr_rec_state_e    state_q, state_d;
  logic [PW-1:0]     persist_q, persist_d, persist_inc;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [NHARTS-1:0] cap_id_q, cap_id_d;
  logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;
  logic              confirm;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      persist_q   <= '0;
      tmo_q       <= '0;
      cap_id_q    <= '0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      persist_q   <= persist_d;
      tmo_q       <= tmo_d;
      cap_id_q    <= cap_id_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign persist_inc = persist_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    persist_d   = persist_q;
    tmo_d       = tmo_q;
    cap_id_d    = cap_id_q;
    fault_cnt_d = fault_cnt_q;
    confirm     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d     = '0;
        persist_d = '0;
        if (enable_i && error_i) begin
          if ($onehot(error_id_i)) begin
            cap_id_d = error_id_i;
            if (ERR_PERSIST == 1) begin
              state_d = ST_HALT_REQ;
              confirm = 1'b1;
            end else begin
              state_d   = ST_FILTER;
              persist_d = PW'(1);
            end
          end else begin
            state_d = ST_FATAL;
          end
        end
      end
      ST_FILTER: begin
        if (!error_i) begin
          // Transient mismatch: drop it without counting.
          state_d   = ST_IDLE;
          persist_d = '0;
          cap_id_d  = '0;
        end else if (!$onehot(error_id_i)) begin
          state_d = ST_FATAL;
        end else if (error_id_i != cap_id_q) begin
          cap_id_d  = error_id_i;
          persist_d = PW'(1);
        end else if (persist_inc == PW'(ERR_PERSIST)) begin
          state_d   = ST_HALT_REQ;
          persist_d = '0;
          confirm   = 1'b1;
        end else begin
          persist_d = persist_inc;
        end
      end
      ST_HALT_REQ: begin
        // All-halted takes priority over an expiring timeout in the same cycle.
        if (&halted_i) begin
          state_d = ST_RESYNC;
          tmo_d   = '0;
        end else if (tmo_q == TW'(HALT_TIMEOUT - 1)) begin
          state_d = ST_FATAL;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESYNC: begin
        if (resync_done_i) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (~|halted_i) begin
          state_d  = ST_IDLE;
          cap_id_d = '0;
        end
      end
      ST_FATAL: state_d = ST_FATAL;
      default:  state_d = ST_FATAL;
    endcase

    if (confirm && (fault_cnt_q != '1)) fault_cnt_d = fault_cnt_q + CNT_W'(1);
  end

  assign recovering_o  = (state_q == ST_HALT_REQ) || (state_q == ST_RESYNC) ||
                         (state_q == ST_RELEASE);
  assign fatal_o       = (state_q == ST_FATAL);
  assign debug_req_o   = ((state_q == ST_HALT_REQ) || (state_q == ST_FATAL)) ? '1 : '0;
  assign faulty_id_o   = recovering_o ? cap_id_q : '0;
  assign fault_count_o = fault_cnt_q;

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Directed bench for tmr_recovery_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tmr_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        error_i;
  logic [2:0]  error_id_i;
  logic [2:0]  halted_i;
  logic        resync_done_i;
  logic [2:0]  debug_req_o;
  logic [2:0]  faulty_id_o;
  logic        recovering_o;
  logic        fatal_o;
  logic [15:0] fault_count_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tmr_recovery_ctrl #(
    .NHARTS(3), .ERR_PERSIST(2), .HALT_TIMEOUT(1024), .CNT_W(16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable_i),
    .error_i       (error_i),
    .error_id_i    (error_id_i),
    .halted_i      (halted_i),
    .resync_done_i (resync_done_i),
    .debug_req_o   (debug_req_o),
    .faulty_id_o   (faulty_id_o),
    .recovering_o  (recovering_o),
    .fatal_o       (fatal_o),
    .fault_count_o (fault_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input logic [15:0] cnt);
    check({tag, " debug_req"},  32'(debug_req_o),   32'h0);
    check({tag, " faulty_id"},  32'(faulty_id_o),   32'h0);
    check({tag, " recovering"}, 32'(recovering_o),  32'h0);
    check({tag, " fatal"},      32'(fatal_o),       32'h0);
    check({tag, " count"},      32'(fault_count_o), 32'(cnt));
  endtask

  // Called on a falling edge; returns on the falling edge after HALT_REQ entry.
  task automatic confirm_fault(input logic [2:0] id);
    error_i = 1'b1; error_id_i = id;
    @(negedge clk);
    @(negedge clk);
    error_i = 1'b0; error_id_i = 3'b000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic dbg_seen;
    rst_n = 1'b0; enable_i = 1'b1; error_i = 1'b0; error_id_i = 3'b000;
    halted_i = 3'b000; resync_done_i = 1'b0;
    #1;
    check_quiet("reset", 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // No fault for 1000 cycles
    repeat (1000) @(negedge clk);
    check_quiet("no_fault", 16'd0);

    // Single-cycle transient
    dbg_seen = 1'b0;
    error_i = 1'b1; error_id_i = 3'b010;
    @(negedge clk);
    error_i = 1'b0; error_id_i = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (debug_req_o != 3'b000) dbg_seen = 1'b1;
    end
    check("transient dbg_seen", 32'(dbg_seen), 32'h0);
    check_quiet("transient", 16'd0);

    // Full recovery
    error_i = 1'b1; error_id_i = 3'b100;
    @(negedge clk);
    check("filter debug_req", 32'(debug_req_o), 32'h0);
    @(negedge clk);
    error_i = 1'b0; error_id_i = 3'b000;
    check("halt debug_req",  32'(debug_req_o),  32'h7);
    check("halt faulty_id",  32'(faulty_id_o),  32'h4);
    check("halt recovering", 32'(recovering_o), 32'h1);
    check("halt count",      32'(fault_count_o), 32'h1);
    halted_i = 3'b111;
    @(negedge clk);
    check("resync debug_req",  32'(debug_req_o),  32'h0);
    check("resync recovering", 32'(recovering_o), 32'h1);
    // Errors and enable changes are ignored once recovery is underway.
    error_i = 1'b1; error_id_i = 3'b011; enable_i = 1'b0;
    repeat (3) @(negedge clk);
    error_i = 1'b0; error_id_i = 3'b000;
    check("resync hold fatal",     32'(fatal_o),      32'h0);
    check("resync hold faulty_id", 32'(faulty_id_o),  32'h4);
    resync_done_i = 1'b1;
    @(negedge clk);
    resync_done_i = 1'b0;
    check("release recovering", 32'(recovering_o), 32'h1);
    check("release debug_req",  32'(debug_req_o),  32'h0);
    halted_i = 3'b000;
    @(negedge clk);
    check_quiet("recovered", 16'd1);
    enable_i = 1'b1;

    // Re-capture in the filter, then halt timeout
    error_i = 1'b1; error_id_i = 3'b001;
    @(negedge clk);
    error_id_i = 3'b010;
    @(negedge clk);
    check("recapture recovering", 32'(recovering_o), 32'h0);
    @(negedge clk);
    error_i = 1'b0; error_id_i = 3'b000;
    halted_i = 3'b011;
    check("recapture faulty_id", 32'(faulty_id_o),  32'h2);
    check("recapture count",     32'(fault_count_o), 32'h2);
    repeat (1023) @(negedge clk);
    check("tmo edge fatal",      32'(fatal_o),      32'h0);
    check("tmo edge recovering", 32'(recovering_o), 32'h1);
    @(negedge clk);
    check("tmo fatal",      32'(fatal_o),      32'h1);
    check("tmo debug_req",  32'(debug_req_o),  32'h7);
    check("tmo recovering", 32'(recovering_o), 32'h0);
    halted_i = 3'b111; resync_done_i = 1'b1;
    repeat (20) @(negedge clk);
    halted_i = 3'b000; resync_done_i = 1'b0;
    repeat (5) @(negedge clk);
    check("fatal sticky", 32'(fatal_o), 32'h1);

    do_reset();
    check_quiet("post_fatal reset", 16'd0);

    // Ambiguous id
    error_i = 1'b1; error_id_i = 3'b011;
    @(negedge clk);
    error_i = 1'b0; error_id_i = 3'b000;
    check("ambig fatal",     32'(fatal_o),     32'h1);
    check("ambig debug_req", 32'(debug_req_o), 32'h7);
    check("ambig count",     32'(fault_count_o), 32'h0);
    do_reset();

    // Async reset in the middle of RESYNC
    confirm_fault(3'b001);
    check("pre_rst count", 32'(fault_count_o), 32'h1);
    halted_i = 3'b111;
    @(negedge clk);
    check("pre_rst recovering", 32'(recovering_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("async reset", 16'd0);
    halted_i = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Disabled: error pulses do nothing
    enable_i = 1'b0;
    error_i = 1'b1; error_id_i = 3'b010;
    repeat (3) @(negedge clk);
    error_id_i = 3'b110;
    @(negedge clk);
    error_i = 1'b0; error_id_i = 3'b000;
    @(negedge clk);
    check_quiet("disabled", 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
